// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the writeback stage: ID control-bit indices,
// load funct3 encodings and the FSM state type.
package wb_stage_pkg;

  localparam int unsigned MEMTOREG = 1;
  localparam int unsigned REGWRITE = 0;
  localparam int unsigned MEMREAD  = 1;
  localparam int unsigned MEMWRITE = 0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    StIdle,
    StWaitMem,
    StCommit
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB retire handshake plus the data-memory load response.
interface wb_stage_if #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               in_flush;
  logic [1:0]         in_ctrl_wb;
  logic [1:0]         in_ctrl_m;
  logic [2:0]         in_funct3;
  logic [RADDR_W-1:0] in_rd;
  logic [XLEN-1:0]    in_alu_result;
  logic               mem_rsp_valid;
  logic [XLEN-1:0]    mem_rsp_data;

  modport master (
    output in_valid, in_flush, in_ctrl_wb, in_ctrl_m, in_funct3, in_rd, in_alu_result,
    output mem_rsp_valid, mem_rsp_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_flush, in_ctrl_wb, in_ctrl_m, in_funct3, in_rd, in_alu_result,
    input  mem_rsp_valid, mem_rsp_data,
    output in_ready
  );
endinterface

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/half/word/double at the given
// offset of an aligned doubleword and sign- or zero-extends it.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] w;

  // Misaligned offsets drop their low bits for the wider sizes.
  assign b = 8'(data >> {offset, 3'b000});
  assign h = 16'(data >> {offset[2:1], 4'b0000});
  assign w = 32'(data >> {offset[2], 5'b00000});

  always_comb begin
    result = data;
    unique case (funct3)
      F3_LB:   result = {{(XLEN-8){b[7]}}, b};
      F3_LH:   result = {{(XLEN-16){h[15]}}, h};
      F3_LW:   result = {{(XLEN-32){w[31]}}, w};
      F3_LD:   result = data;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, h};
      F3_LWU:  result = {{(XLEN-32){1'b0}}, w};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, waits for load data and
// commits one register-file write per instruction back into ID.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_stage_if.slave          bus,
  output logic               op_write,
  output logic [RADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]    write_data,
  output logic [CNT_W-1:0]   retired,
  output logic               rsp_err
);

  wb_state_e          state_q, state_d;
  logic [RADDR_W-1:0] rd_q, rd_d, wa_q, wa_d;
  logic [XLEN-1:0]    wd_q, wd_d;
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d, off_q, off_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic               err_q, err_d;
  logic               accept, is_load, wr_en_in;
  logic [XLEN-1:0]    load_data;

  load_align #(.XLEN(XLEN)) u_align (
    .data   (bus.mem_rsp_data),
    .offset (off_q),
    .funct3 (f3_q),
    .result (load_data)
  );

  assign bus.in_ready = (state_q != StWaitMem);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.in_flush;
  assign is_load      = bus.in_ctrl_m[MEMREAD] & bus.in_ctrl_wb[MEMTOREG];
  assign wr_en_in     = bus.in_ctrl_wb[REGWRITE] & (bus.in_rd != '0);

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    ret_d   = ret_q + ((state_q == StCommit) ? CNT_W'(1) : CNT_W'(0));
    err_d   = err_q | (bus.mem_rsp_valid & (state_q != StWaitMem));
    unique case (state_q)
      StIdle, StCommit: begin
        state_d = StIdle;
        if (accept) begin
          we_d = wr_en_in;
          if (is_load) begin
            rd_d    = bus.in_rd;
            f3_d    = bus.in_funct3;
            off_d   = bus.in_alu_result[2:0];
            state_d = StWaitMem;
          end else begin
            // Output regs only move when a real write is committed.
            if (wr_en_in) begin
              wa_d = bus.in_rd;
              wd_d = bus.in_alu_result;
            end
            state_d = StCommit;
          end
        end
      end
      StWaitMem: begin
        if (bus.mem_rsp_valid) begin
          if (we_q) begin
            wa_d = rd_q;
            wd_d = load_data;
          end
          state_d = StCommit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      rd_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      ret_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      ret_q   <= ret_d;
      err_q   <= err_d;
    end
  end

  assign op_write   = (state_q == StCommit) & we_q;
  assign write_addr = wa_q;
  assign write_data = wd_q;
  assign retired    = ret_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: table-driven load extraction plus
// hand-written handshake, squash, error and reset sequences.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_write, op_write_s;
  logic [4:0]  write_addr, write_addr_s;
  logic [63:0] write_data, write_data_s;
  logic [31:0] retired;
  logic [3:0]  retired_s;
  logic        rsp_err, rsp_err_s;

  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;

  wb_stage_if #(.XLEN(64), .RADDR_W(5)) bus ();
  wb_stage_if #(.XLEN(64), .RADDR_W(5)) bus_s ();

  wb_stage #(.XLEN(64), .RADDR_W(5), .CNT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .op_write   (op_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .retired    (retired),
    .rsp_err    (rsp_err)
  );

  // Narrow counter instance so the wrap can be reached in a few cycles.
  wb_stage #(.XLEN(64), .RADDR_W(5), .CNT_W(4)) dut_s (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_s),
    .op_write   (op_write_s),
    .write_addr (write_addr_s),
    .write_data (write_data_s),
    .retired    (retired_s),
    .rsp_err    (rsp_err_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
  } ld_vec_t;

  ld_vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic fl, input logic [1:0] wb,
                       input logic [1:0] m, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] alu);
    bus.in_valid      = v;
    bus.in_flush      = fl;
    bus.in_ctrl_wb    = wb;
    bus.in_ctrl_m     = m;
    bus.in_funct3     = f3;
    bus.in_rd         = rd;
    bus.in_alu_result = alu;
  endtask

  // Load accepted at the next edge, response presented dly cycles later.
  task automatic do_load(input string name, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [4:0] rd, input logic [63:0] data, input int dly,
                         input logic [63:0] exp);
    drive(1'b1, 1'b0, 2'b11, 2'b10, f3, rd, addr);
    for (int c = 0; c < dly; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("%s ready_low%0d", name, c), {63'd0, bus.in_ready}, 64'd0);
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    exp_ret++;
    chk({name, " op_write"}, {63'd0, op_write}, 64'd1);
    chk({name, " addr"}, {59'd0, write_addr}, {59'd0, rd});
    chk({name, " data"}, write_data, exp);
  endtask

  localparam logic [63:0] D = 64'h8877_6655_4433_2211;

  initial begin
    vecs[0]  = '{F3_LB,  64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{F3_LBU, 64'h1003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080};
    vecs[2]  = '{F3_LH,  64'h2006, D, 64'hFFFF_FFFF_FFFF_8877};
    vecs[3]  = '{F3_LHU, 64'h2002, D, 64'h0000_0000_0000_4433};
    vecs[4]  = '{F3_LW,  64'h2004, D, 64'hFFFF_FFFF_8877_6655};
    vecs[5]  = '{F3_LWU, 64'h2004, D, 64'h0000_0000_8877_6655};
    vecs[6]  = '{F3_LW,  64'h2000, D, 64'h0000_0000_4433_2211};
    vecs[7]  = '{F3_LD,  64'h2000, D, D};
    vecs[8]  = '{3'b111, 64'h2000, D, D};
    vecs[9]  = '{F3_LH,  64'h2003, D, 64'h0000_0000_0000_4433};
    vecs[10] = '{F3_LB,  64'h2007, D, 64'hFFFF_FFFF_FFFF_FF88};
    vecs[11] = '{F3_LBU, 64'h2005, D, 64'h0000_0000_0000_0066};
    vecs[12] = '{F3_LW,  64'h2005, D, 64'hFFFF_FFFF_8877_6655};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 5'd0, 64'd0);
    bus.mem_rsp_valid      = 1'b0;
    bus.mem_rsp_data       = '0;
    bus_s.in_valid         = 1'b0;
    bus_s.in_flush         = 1'b0;
    bus_s.in_ctrl_wb       = 2'b00;
    bus_s.in_ctrl_m        = 2'(1 << MEMWRITE);
    bus_s.in_funct3        = 3'b000;
    bus_s.in_rd            = 5'd0;
    bus_s.in_alu_result    = '0;
    bus_s.mem_rsp_valid    = 1'b0;
    bus_s.mem_rsp_data     = '0;
    repeat (2) @(negedge clk);
    chk("reset op_write", {63'd0, op_write}, 64'd0);
    chk("reset addr", {59'd0, write_addr}, 64'd0);
    chk("reset data", write_data, 64'd0);
    chk("reset retired", {32'd0, retired}, 64'd0);
    chk("reset rsp_err", {63'd0, rsp_err}, 64'd0);
    chk("reset ready", {63'd0, bus.in_ready}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // addi x3, 5: write visible one cycle after acceptance
    drive(1'b1, 1'b0, 2'b01, 2'b00, 3'b000, 5'd3, 64'h5);
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp_ret++;
    chk("addi op_write", {63'd0, op_write}, 64'd1);
    chk("addi addr", {59'd0, write_addr}, 64'd3);
    chk("addi data", write_data, 64'h5);
    @(negedge clk);
    chk("addi op_write_drop", {63'd0, op_write}, 64'd0);
    chk("addi retired", {32'd0, retired}, 64'd1);
    chk("addi addr_hold", {59'd0, write_addr}, 64'd3);

    for (int i = 0; i < 13; i++) begin
      do_load($sformatf("load%0d", i), vecs[i].f3, vecs[i].addr, 5'(i + 5), vecs[i].data,
              (i == 0) ? 3 : 1 + (i % 3), vecs[i].exp);
    end

    // Four back-to-back R-type instructions, one write per cycle
    drive(1'b1, 1'b0, 2'b11, 2'b00, 3'b000, 5'd1, 64'h101);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_ret++;
      chk($sformatf("b2b%0d op_write", i), {63'd0, op_write}, 64'd1);
      chk($sformatf("b2b%0d addr", i), {59'd0, write_addr}, 64'(i + 1));
      chk($sformatf("b2b%0d data", i), write_data, 64'h101 + 64'(i));
      chk($sformatf("b2b%0d ready", i), {63'd0, bus.in_ready}, 64'd1);
      if (i < 3) drive(1'b1, 1'b0, 2'b11, 2'b00, 3'b000, 5'(i + 2), 64'h102 + 64'(i));
      else bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b retired", {32'd0, retired}, 64'(exp_ret));

    // rd=0 with RegWrite, then a store: counted, never written
    drive(1'b1, 1'b0, 2'b01, 2'b00, 3'b000, 5'd0, 64'hDEAD);
    @(negedge clk);
    chk("x0 op_write", {63'd0, op_write}, 64'd0);
    drive(1'b1, 1'b0, 2'b00, 2'(1 << MEMWRITE), 3'b011, 5'd7, 64'hBEEF);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("store op_write", {63'd0, op_write}, 64'd0);
    chk("store addr_hold", {59'd0, write_addr}, 64'd4);
    chk("store data_hold", write_data, 64'h104);
    exp_ret += 2;
    @(negedge clk);
    chk("x0+store retired", {32'd0, retired}, 64'(exp_ret));

    // Flushed addi has no effect
    drive(1'b1, 1'b1, 2'b01, 2'b00, 3'b000, 5'd5, 64'h7);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 5'd0, 64'd0);
    chk("flush op_write", {63'd0, op_write}, 64'd0);
    @(negedge clk);
    chk("flush op_write2", {63'd0, op_write}, 64'd0);
    chk("flush retired", {32'd0, retired}, 64'(exp_ret));
    chk("flush addr_hold", {59'd0, write_addr}, 64'd4);

    // Stray response in IDLE sets the sticky error
    chk("err clear", {63'd0, rsp_err}, 64'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hFFFF;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk("err set", {63'd0, rsp_err}, 64'd1);
    chk("err no_write", {63'd0, op_write}, 64'd0);
    repeat (3) @(negedge clk);
    chk("err sticky", {63'd0, rsp_err}, 64'd1);
    chk("err retired", {32'd0, retired}, 64'(exp_ret));

    // Reset while waiting for load data, then a late response
    drive(1'b1, 1'b0, 2'b11, 2'b10, F3_LD, 5'd9, 64'h3000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rst_mid waiting", {63'd0, bus.in_ready}, 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_mid retired", {32'd0, retired}, 64'd0);
    chk("rst_mid err", {63'd0, rsp_err}, 64'd0);
    chk("rst_mid addr", {59'd0, write_addr}, 64'd0);
    chk("rst_mid data", write_data, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'h1234;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk("late_rsp op_write", {63'd0, op_write}, 64'd0);
    chk("late_rsp err", {63'd0, rsp_err}, 64'd1);
    @(negedge clk);
    chk("late_rsp op_write2", {63'd0, op_write}, 64'd0);
    chk("late_rsp retired", {32'd0, retired}, 64'd0);
    chk("late_rsp data", write_data, 64'd0);

    // Counter wrap on the 4-bit instance: 16 stores back to back
    bus_s.in_valid = 1'b1;
    repeat (16) @(negedge clk);
    bus_s.in_valid = 1'b0;
    chk("wrap pre", {60'd0, retired_s}, 64'd15);
    @(negedge clk);
    chk("wrap zero", {60'd0, retired_s}, 64'd0);
    chk("wrap no_write", {63'd0, op_write_s}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback end of the decode register-file write port: drives op_write/write_addr/write_data back into ID.
- Accepts retiring instructions from the MEM stage via valid/ready, carrying the ctrl_wb/ctrl_m bits ID generated.
- Waits for the data-memory load response, aligns and sign/zero-extends it, and commits exactly one register write per instruction.
- Provides a retired-instruction counter and a protocol-error flag.

Parameters:
XLEN, 64, datapath and register width
RADDR_W, 5, register address width
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept this cycle
in_flush  in  1  squash the instruction presented this cycle
in_ctrl_wb  in  2  [1]=MemtoReg, [0]=RegWrite (ID ctrl_wb encoding)
in_ctrl_m  in  2  [1]=MemRead, [0]=MemWrite (ID ctrl_m encoding)
in_funct3  in  3  load width/sign: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
in_rd  in  RADDR_W  destination register
in_alu_result  in  XLEN  ALU result; for loads, the byte address
mem_rsp_valid  in  1  load data valid (single-cycle pulse)
mem_rsp_data  in  XLEN  aligned 64-bit doubleword containing the load
op_write  out  1  register-file write enable to ID
write_addr  out  RADDR_W  register-file write address
write_data  out  XLEN  register-file write data
retired  out  CNT_W  count of committed (non-squashed) instructions
rsp_err  out  1  sticky: unexpected mem_rsp_valid

Behaviour:
- Reset (async, reset_n low): state IDLE; op_write=0, write_addr=0, write_data=0, retired=0, rsp_err=0, in_ready=1.
- Reset mid-load abandons the load with no write.
- Accept condition: in_valid & in_ready & ~in_flush. A flushed or invalid cycle has no effect.
- Load: accepted with in_ctrl_m[1]=1 and in_ctrl_wb[1]=1. Every other accepted instruction is non-load.
- States:
  - IDLE: in_ready=1.
    - Non-load accepted: register rd/result, go COMMIT.
    - Load accepted: register rd, funct3, addr[2:0], go WAIT_MEM.
  - WAIT_MEM: in_ready=0.
    - On mem_rsp_valid: extract the field, register write_data, go COMMIT.
    - mem_rsp_valid in the same cycle as load acceptance is not consumed; the response must arrive at or after the next cycle.
  - COMMIT: drive op_write for exactly one cycle; increment retired (wraps at 2^CNT_W); in_ready=1.
    - A new instruction may be accepted in COMMIT (back-to-back). Next state per IDLE rules, otherwise IDLE.
- Latency:
  - Non-load accepted at cycle N: op_write high at N+1.
  - Load whose response arrives at cycle M: op_write high at M+1.
  - Back-to-back non-loads sustain 1 write per cycle.
- op_write = COMMIT & RegWrite & (rd != 0). x0 is never written; retired still increments.
- write_addr/write_data hold their last values when op_write is low.
- Load extraction: byte offset = addr[2:0].
  - lb/lbu: byte at offset.
  - lh/lhu: halfword at offset[2:1].
  - lw/lwu: word at offset[2].
  - ld: full doubleword.
  - Signed forms sign-extend to XLEN; unsigned forms zero-extend.
  - Misaligned offsets use the low aligned bits only (offset truncated). Reserved funct3=111 is treated as ld.
- Stores (MemWrite, RegWrite=0) and branches pass through COMMIT with op_write=0 and are counted.
- rsp_err sets on mem_rsp_valid in any state other than WAIT_MEM; it clears only on reset. Such a response is otherwise ignored.
- in_flush while in WAIT_MEM has no effect: an accepted load is already committed to complete.

Decomposition:
- Shared package holds:
  - the ctrl_wb/ctrl_m bit-index constants (MEMTOREG=1, REGWRITE=0, MEMREAD=1, MEMWRITE=0);
  - the load funct3 encodings;
  - the FSM state enum.
- One sub-module, load_align: purely combinational extraction/extension from (data, offset, funct3). It is unit-tested separately.

Test Plan:
- Reset, then addi result 0x5, rd=3, ctrl_wb=01 accepted at cycle N -> op_write=1 at N+1, addr 3, data 0x5; retired=1.
- Load lb, addr 0x1003, mem_rsp_data=0x0000_0000_8000_0000 arriving 3 cycles later -> in_ready low while waiting; one cycle after the response, write_data=0xFFFF_FFFF_FFFF_FF80 (lbu gives 0x80).
- Four back-to-back R-type (ctrl_wb=11, MemRead=0), rd=1..4 -> four consecutive op_write cycles with ALU data; no stall.
- rd=0 with RegWrite=1, plus a store (ctrl_wb=00) -> op_write never high; retired increments by 2.
- in_flush with in_valid on an addi -> no write, retired unchanged. mem_rsp_valid pulse in IDLE -> rsp_err=1 and stays 1.
- reset_n low mid-WAIT_MEM, then a late mem_rsp_valid after release -> no write; rsp_err=1. Also preload retired=2^32-1 via a long run and check wrap to 0.
